// File: rtl/roi_capture_pkg.sv
// Shared constants for the ROI capture controller: register map, FSM encoding,
// CTRL/STATUS bit positions and the lane-packing helper.
package roi_capture_pkg;

  localparam logic [2:0] ADDR_CTRL      = 3'd0;
  localparam logic [2:0] ADDR_STATUS    = 3'd1;
  localparam logic [2:0] ADDR_ROI_X     = 3'd2;
  localparam logic [2:0] ADDR_ROI_Y     = 3'd3;
  localparam logic [2:0] ADDR_FIFO_DATA = 3'd4;
  localparam logic [2:0] ADDR_PIX_COUNT = 3'd5;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ARMED   = 2'd1;
  localparam state_t ST_CAPTURE = 2'd2;
  localparam state_t ST_DONE    = 2'd3;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int STATUS_DONE  = 2;
  localparam int STATUS_OVF   = 3;
  localparam int STATUS_EMPTY = 4;
  localparam int STATUS_FULL  = 5;

  // Word to push when the byte for lane idx arrives: lower lanes from the pack
  // register, this byte in lane idx, upper lanes zero (padding for a short tail).
  function automatic logic [31:0] pack_word(input logic [31:0] pack,
                                            input logic [1:0]  idx,
                                            input logic [7:0]  luma);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(idx))       w[8*i +: 8] = pack[8*i +: 8];
      else if (i == int'(idx)) w[8*i +: 8] = luma;
    end
    return w;
  endfunction

endpackage

// File: rtl/roi_sync_fifo.sv
// Single-clock show-ahead FIFO with flush; a pop in the same cycle frees the slot
// for a push into a full FIFO, while a pop on empty is ignored.
module roi_sync_fifo #(
  parameter int DEPTH = 256,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop & ~empty & ~flush;
  assign do_push  = push & ~flush & (~full | do_pop);
  assign overflow = push & ~flush & full & ~do_pop;
  assign rdata    = mem[rd_ptr];

  // NOTE: storage has no reset; count/pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: reset is synchronous and all state uses non-blocking assignment.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/roi_capture_ctrl.sv
// Avalon-MM ROI capture controller: arms on software start, captures one frame's
// ROI luma bytes from the pixel stream, packs four per word into a FIFO.
module roi_capture_ctrl
  import roi_capture_pkg::*;
#(
  parameter int FIFO_DEPTH = 256,
  parameter int COORD_W    = 11
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         addr,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic [7:0]         pix_luma,
  output logic               irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t             state_q;
  logic               irq_en_q, done_q, ovf_q;
  logic [COORD_W-1:0] x0_q, x1_q, y0_q, y1_q;
  logic [31:0]        pix_count_q, pack_q;
  logic [1:0]         idx_q;

  logic               ctrl_wr, status_wr, start_cmd, abort_cmd, fifo_flush;
  logic               start_pix, in_roi, at_end, accept, push;
  logic [31:0]        push_word, fifo_rdata, status_word;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full, fifo_empty, fifo_ovf, fifo_pop;
  logic               unused_wdata;

  assign ctrl_wr    = wr_en & (addr == ADDR_CTRL);
  assign status_wr  = wr_en & (addr == ADDR_STATUS);
  assign start_cmd  = ctrl_wr & writedata[CTRL_START] & (state_q == ST_IDLE);
  assign abort_cmd  = ctrl_wr & writedata[CTRL_ABORT];
  assign fifo_flush = abort_cmd | start_cmd;
  assign fifo_pop   = rd_en & (addr == ADDR_FIFO_DATA);
  assign unused_wdata = ^writedata;

  // The frame-origin pixel that arms capture is itself eligible in the same cycle.
  assign start_pix = pix_valid && (pix_x == '0) && (pix_y == '0);
  assign in_roi    = (pix_x >= x0_q) && (pix_x <= x1_q) && (pix_y >= y0_q) && (pix_y <= y1_q);
  assign at_end    = (pix_x == x1_q) && (pix_y == y1_q);
  assign accept    = pix_valid && in_roi &&
                     ((state_q == ST_CAPTURE) || ((state_q == ST_ARMED) && start_pix));
  assign push      = accept && ((idx_q == 2'd3) || at_end) && !abort_cmd;
  assign push_word = pack_word(pack_q, idx_q, pix_luma);
  assign irq       = done_q & irq_en_q;

  roi_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .wdata    (push_word),
    .rdata    (fifo_rdata),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (fifo_ovf)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      x0_q        <= '0;
      x1_q        <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      pix_count_q <= '0;
      pack_q      <= '0;
      idx_q       <= '0;
    end else begin
      if (ctrl_wr) irq_en_q <= writedata[CTRL_IRQ_EN];
      if (wr_en && addr == ADDR_ROI_X) begin
        x0_q <= writedata[COORD_W-1:0];
        x1_q <= writedata[16 +: COORD_W];
      end
      if (wr_en && addr == ADDR_ROI_Y) begin
        y0_q <= writedata[COORD_W-1:0];
        y1_q <= writedata[16 +: COORD_W];
      end
      if (status_wr && writedata[STATUS_DONE]) done_q <= 1'b0;
      if (status_wr && writedata[STATUS_OVF])  ovf_q  <= 1'b0;
      // Hardware set events sit after the W1C clears so a coincident set wins.
      if (fifo_ovf) ovf_q <= 1'b1;

      if (abort_cmd) begin
        state_q <= ST_IDLE;
        pack_q  <= '0;
        idx_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: if (start_cmd) begin
            state_q     <= ST_ARMED;
            pix_count_q <= '0;
            pack_q      <= '0;
            idx_q       <= '0;
          end
          ST_ARMED, ST_CAPTURE: begin
            if (state_q == ST_ARMED && start_pix) state_q <= ST_CAPTURE;
            if (accept) begin
              pix_count_q <= pix_count_q + 32'd1;
              pack_q[{idx_q, 3'b000} +: 8] <= pix_luma;
              if (at_end) begin
                idx_q   <= '0;
                state_q <= ST_DONE;
              end else begin
                idx_q <= idx_q + 2'd1;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    status_word = '0;
    status_word[1:0]          = state_q;
    status_word[STATUS_DONE]  = done_q;
    status_word[STATUS_OVF]   = ovf_q;
    status_word[STATUS_EMPTY] = fifo_empty;
    status_word[STATUS_FULL]  = fifo_full;
    status_word[31:16]        = 16'(fifo_count);
  end

  // NOTE: always_comb outputs take a default first so no path infers a latch.
  always_comb begin
    readdata = '0;
    if (rd_en) begin
      case (addr)
        ADDR_CTRL:      readdata[CTRL_IRQ_EN] = irq_en_q;
        ADDR_STATUS:    readdata = status_word;
        ADDR_ROI_X: begin
          readdata[COORD_W-1:0]  = x0_q;
          readdata[16 +: COORD_W] = x1_q;
        end
        ADDR_ROI_Y: begin
          readdata[COORD_W-1:0]  = y0_q;
          readdata[16 +: COORD_W] = y1_q;
        end
        ADDR_FIFO_DATA: if (!fifo_empty) readdata = fifo_rdata;
        ADDR_PIX_COUNT: readdata = pix_count_q;
        default:        readdata = '0;
      endcase
    end
  end

endmodule
